ampere_time_ctrl: RTL and testbench

Timekeeping and needle-sequencing controller for the ammeter clock. Counts hours/minutes/seconds from the system clock and drives the `time_data` indices of the three meter PWM channels (hour, min, second). Increments are forwarded directly; wrap-arounds and manual time sets are slew-limited so the needles sweep rather than slam. An optional power-up full-scale self-test sweep is also provided.

---
 rtl/ampere_ctrl_pkg.sv | 20 ++
 rtl/ampere_time_ctrl_if.sv | 26 ++
 rtl/needle_slew.sv | 41 ++++
 rtl/ampere_time_ctrl.sv | 114 +++++++++++
 tb/tb_ampere_time_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ampere_ctrl_pkg.sv
// rtl/ampere_ctrl_pkg.sv - shared state enum, index width and range constants for the ammeter clock
// SELFTEST_* states exist only when AMPERE_SELFTEST_EN is defined.
package ampere_ctrl_pkg;

  localparam int IDX_W = 8;
  localparam logic [IDX_W-1:0] SEC_MAX = 8'd59;
  localparam logic [IDX_W-1:0] MIN_MAX = 8'd59;

`ifdef AMPERE_SELFTEST_EN
  typedef enum logic [1:0] {SELFTEST_UP, SELFTEST_DN, RUN} state_t;
`else
  typedef enum logic [0:0] {RUN} state_t;
`endif

  function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] v,
                                                 input logic [IDX_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/ampere_time_ctrl_if.sv
// rtl/ampere_time_ctrl_if.sv - time-set request channel and meter index outputs
interface ampere_time_ctrl_if;
  import ampere_ctrl_pkg::*;

  logic             set_valid;
  logic [4:0]       set_hour;
  logic [5:0]       set_min;
  logic [5:0]       set_sec;
  logic             set_ready;
  logic [IDX_W-1:0] hour_data;
  logic [IDX_W-1:0] min_data;
  logic [IDX_W-1:0] sec_data;
  logic             tick_1hz;
  logic             busy;

  modport master (
    output set_valid, set_hour, set_min, set_sec,
    input  set_ready, hour_data, min_data, sec_data, tick_1hz, busy
  );

  modport slave (
    input  set_valid, set_hour, set_min, set_sec,
    output set_ready, hour_data, min_data, sec_data, tick_1hz, busy
  );

endinterface

// File: rtl/needle_slew.sv
// rtl/needle_slew.sv - one meter channel: direct +1 steps, otherwise one unit per SLEW_DIV cycles
module needle_slew
  import ampere_ctrl_pkg::*;
#(
  parameter int SLEW_DIV = 500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] target,
  output logic [IDX_W-1:0] data,
  output logic             settled
);

  localparam int CW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [CW-1:0]    STEP_LAST = CW'(SLEW_DIV - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

  logic [CW-1:0] step_cnt;

  // A target change mid-slew only redirects; step_cnt keeps running until settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data     <= '0;
      step_cnt <= '0;
    end else if (data == target) begin
      step_cnt <= '0;
    end else if (target == data + ONE) begin
      data     <= target;
      step_cnt <= '0;
    end else if (step_cnt == STEP_LAST) begin
      step_cnt <= '0;
      data     <= (target > data) ? data + ONE : data - ONE;
    end else begin
      step_cnt <= step_cnt + CNT_ONE;
    end
  end

  assign settled = (data == target);

endmodule

// File: rtl/ampere_time_ctrl.sv
// rtl/ampere_time_ctrl.sv - hh:mm:ss timekeeping and needle sequencing for the ammeter clock
// Define AMPERE_SELFTEST_EN for the power-up full-scale sweep.
module ampere_time_ctrl
  import ampere_ctrl_pkg::*;
#(
  parameter int SYSCLKHZ = 50_000_000,
  parameter int SLEW_DIV = 500_000,
  parameter int HOURS    = 12
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               En,
  ampere_time_ctrl_if.slave  bus
);

  localparam int PW = (SYSCLKHZ > 1) ? $clog2(SYSCLKHZ) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(SYSCLKHZ - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [IDX_W-1:0] HOUR_MAX   = IDX_W'(HOURS - 1);
  localparam logic [IDX_W-1:0] ONE        = IDX_W'(1);

  state_t           state;
  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] hour_cnt, min_cnt, sec_cnt;
  logic [IDX_W-1:0] hour_tgt, min_tgt, sec_tgt;
  logic             hour_ok, min_ok, sec_ok;
  logic             all_settled;
  logic             set_fire;

  assign set_fire    = bus.set_valid & bus.set_ready;
  assign all_settled = hour_ok & min_ok & sec_ok;
  assign bus.busy    = (state != RUN) | ~all_settled;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
`ifdef AMPERE_SELFTEST_EN
      state <= SELFTEST_UP;
`else
      state <= RUN;
`endif
      presc         <= '0;
      hour_cnt      <= '0;
      min_cnt       <= '0;
      sec_cnt       <= '0;
      bus.tick_1hz  <= 1'b0;
      bus.set_ready <= 1'b0;
    end else begin
      bus.tick_1hz  <= 1'b0;
      bus.set_ready <= (state == RUN);
`ifdef AMPERE_SELFTEST_EN
      if (state == SELFTEST_UP) begin
        if (all_settled) state <= SELFTEST_DN;
      end else if (state == SELFTEST_DN) begin
        if (all_settled) state <= RUN;
      end else
`endif
      // A set on the terminal cycle wins: the tick and increment are dropped.
      if (set_fire) begin
        hour_cnt <= clamp_idx(IDX_W'(bus.set_hour), HOUR_MAX);
        min_cnt  <= clamp_idx(IDX_W'(bus.set_min), MIN_MAX);
        sec_cnt  <= clamp_idx(IDX_W'(bus.set_sec), SEC_MAX);
        presc    <= '0;
      end else if (En) begin
        if (presc == PRESC_LAST) begin
          presc        <= '0;
          bus.tick_1hz <= 1'b1;
          if (sec_cnt == SEC_MAX) begin
            sec_cnt <= '0;
            if (min_cnt == MIN_MAX) begin
              min_cnt  <= '0;
              hour_cnt <= (hour_cnt == HOUR_MAX) ? '0 : hour_cnt + ONE;
            end else begin
              min_cnt <= min_cnt + ONE;
            end
          end else begin
            sec_cnt <= sec_cnt + ONE;
          end
        end else begin
          presc <= presc + PRESC_ONE;
        end
      end
    end
  end

  always_comb begin
    hour_tgt = hour_cnt;
    min_tgt  = min_cnt;
    sec_tgt  = sec_cnt;
`ifdef AMPERE_SELFTEST_EN
    if (state == SELFTEST_UP) begin
      hour_tgt = HOUR_MAX;
      min_tgt  = MIN_MAX;
      sec_tgt  = SEC_MAX;
    end else if (state == SELFTEST_DN) begin
      hour_tgt = '0;
      min_tgt  = '0;
      sec_tgt  = '0;
    end
`endif
  end

  needle_slew #(.SLEW_DIV(SLEW_DIV)) u_hour (
    .clk(clk), .rst(Rst), .target(hour_tgt), .data(bus.hour_data), .settled(hour_ok)
  );

  needle_slew #(.SLEW_DIV(SLEW_DIV)) u_min (
    .clk(clk), .rst(Rst), .target(min_tgt), .data(bus.min_data), .settled(min_ok)
  );

  needle_slew #(.SLEW_DIV(SLEW_DIV)) u_sec (
    .clk(clk), .rst(Rst), .target(sec_tgt), .data(bus.sec_data), .settled(sec_ok)
  );

endmodule

// File: tb/tb_ampere_time_ctrl.sv
// tb/tb_ampere_time_ctrl.sv - scoreboard bench: expected tick time and meter indices queued per tick
module tb_ampere_time_ctrl;

  logic clk = 1'b0;
  logic Rst;
  logic En;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ampere_time_ctrl_if bus();

  ampere_time_ctrl #(.SYSCLKHZ(10), .SLEW_DIV(2), .HOURS(12)) dut (
    .clk(clk), .Rst(Rst), .En(En), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int h; int m; int s; } exp_t;
  exp_t exp_q[$];

  function automatic void check(string name, int act, int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endfunction

  function automatic void push_exp(int c, int h, int m, int s);
    exp_t e;
    e.c = c; e.h = h; e.m = m; e.s = s;
    exp_q.push_back(e);
  endfunction

  // Tick cycle is checked on the tick itself; indices one cycle later, after the direct step.
  initial forever begin
    int t;
    exp_t e;
    @(negedge clk);
    if (bus.tick_1hz) begin
      t = cyc;
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("unexpected_tick_cycle", t, -1);
      end else begin
        e = exp_q.pop_front();
        check("tick_cycle", t, e.c);
        check("tick_hour", int'(bus.hour_data), e.h);
        check("tick_min", int'(bus.min_data), e.m);
        check("tick_sec", int'(bus.sec_data), e.s);
      end
    end
  end

  task automatic do_set(input int h, input int m, input int s);
    bus.set_valid = 1'b1;
    bus.set_hour  = 5'(h);
    bus.set_min   = 6'(m);
    bus.set_sec   = 6'(s);
    @(negedge clk);
    bus.set_valid = 1'b0;
  endtask

  task automatic wait_settled(input string name, input int limit);
    int n = 0;
    while (bus.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int base, n, early_idle;
    Rst = 1'b1;
    En  = 1'b1;
    bus.set_valid = 1'b0;
    bus.set_hour  = '0;
    bus.set_min   = '0;
    bus.set_sec   = '0;
    repeat (3) @(negedge clk);
    check("rst_hour", int'(bus.hour_data), 0);
    check("rst_min", int'(bus.min_data), 0);
    check("rst_sec", int'(bus.sec_data), 0);
    check("rst_tick", int'(bus.tick_1hz), 0);
    check("rst_set_ready", int'(bus.set_ready), 0);
    Rst = 1'b0;
`ifdef AMPERE_SELFTEST_EN
    begin
      int mh = 0, mm = 0, ms = 0;
      n = 0;
      while (!bus.set_ready && n < 2000) begin
        @(negedge clk);
        n++;
        if (int'(bus.hour_data) > mh) mh = int'(bus.hour_data);
        if (int'(bus.min_data) > mm) mm = int'(bus.min_data);
        if (int'(bus.sec_data) > ms) ms = int'(bus.sec_data);
      end
      check("st_ready", int'(bus.set_ready), 1);
      check("st_peak_hour", mh, 11);
      check("st_peak_min", mm, 59);
      check("st_peak_sec", ms, 59);
      check("st_end_sum", int'(bus.hour_data) + int'(bus.min_data) + int'(bus.sec_data), 0);
      check("st_busy", int'(bus.busy), 0);
    end
`else
    // Counting from reset: 60 ticks, one per 10 cycles, carry into minutes on the 60th.
    base = cyc;
    for (int k = 1; k < 60; k++) push_exp(base + 10 * k, 0, 0, k);
    push_exp(base + 600, 0, 1, 59);
    @(negedge clk);
    check("ready_after_release", int'(bus.set_ready), 1);
    check("busy_after_release", int'(bus.busy), 0);
    repeat (599) @(negedge clk);
    En = 1'b0;
    wait_settled("wrap_settle", 500);
    check("wrap_hour", int'(bus.hour_data), 0);
    check("wrap_min", int'(bus.min_data), 1);
    check("wrap_sec", int'(bus.sec_data), 0);

    // 5:59:59 loaded via clamped min/sec fields, then one tick rolls to 6:00:00.
    do_set(5, 63, 60);
    wait_settled("set_settle", 500);
    check("clamp_hour", int'(bus.hour_data), 5);
    check("clamp_min", int'(bus.min_data), 59);
    check("clamp_sec", int'(bus.sec_data), 59);
    En = 1'b1;
    push_exp(cyc + 10, 6, 59, 59);
    repeat (10) @(negedge clk);
    En = 1'b0;
    n = 0;
    early_idle = 0;
    while (bus.sec_data != 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.sec_data != 0 && !bus.busy) early_idle++;
    end
    check("slew_down_cycles", n, 118);
    check("busy_while_slewing", early_idle, 0);
    check("slew_down_min", int'(bus.min_data), 0);
    check("slew_down_busy", int'(bus.busy), 0);

    // Set lands on the terminal cycle: no tick then, next tick 10 cycles later.
    do_set(0, 10, 19);
    wait_settled("preset_settle", 500);
    En = 1'b1;
    base = cyc;
    push_exp(base + 20, 0, 10, 21);
    repeat (9) @(negedge clk);
    do_set(0, 10, 20);
    repeat (10) @(negedge clk);

    // Hold with prescaler at 3 for 50 cycles; 7 more counting cycles to the tick.
    repeat (3) @(negedge clk);
    En = 1'b0;
    repeat (50) @(negedge clk);
    check("hold_hour", int'(bus.hour_data), 0);
    check("hold_min", int'(bus.min_data), 10);
    check("hold_sec", int'(bus.sec_data), 21);
    En = 1'b1;
    push_exp(base + 80, 0, 10, 22);
    repeat (7) @(negedge clk);
    En = 1'b0;

    do_set(20, 10, 22);
    wait_settled("hour_clamp_settle", 500);
    check("hour_clamp", int'(bus.hour_data), 11);

    // Async reset in the middle of a slew.
    do_set(11, 10, 59);
    n = 0;
    while (bus.sec_data != 30 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("midslew_sec", int'(bus.sec_data), 30);
    #1 Rst = 1'b1;
    #1;
    check("async_rst_hour", int'(bus.hour_data), 0);
    check("async_rst_min", int'(bus.min_data), 0);
    check("async_rst_sec", int'(bus.sec_data), 0);
    check("async_rst_ready", int'(bus.set_ready), 0);
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    En  = 1'b1;
    base = cyc;
    push_exp(base + 10, 0, 0, 1);
    push_exp(base + 20, 0, 0, 2);
    repeat (25) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
